reorder_buffer: RTL and testbench

- Dual-wide in-order retirement buffer directly downstream of register_renamer.
- Accepts up to two renamed instructions per cycle, tracking old_dest, new_dest, regwrite and a completion bit for each.
- Marks entries complete from two execute writeback ports.
- Retires up to two entries per cycle in program order and returns the old physical destinations to the renamer free list through its en_free_reg*/free_reg* inputs.

---
 rtl/rob_pkg.sv | 22 ++
 rtl/rob_commit_select.sv | 26 ++
 rtl/reorder_buffer.sv | 166 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared widths and entry layout for the reorder buffer and its commit selector.
package rob_pkg;

  localparam int ROB_NUM_ENTRIES = 16;
  localparam int ROB_NUM_A_REGS  = 32;
  localparam int ROB_NUM_P_REGS  = 64;

  localparam int ROB_IDX_W    = $clog2(ROB_NUM_ENTRIES);
  localparam int PREG_W       = $clog2(ROB_NUM_P_REGS);
  localparam int AREG_W       = $clog2(ROB_NUM_A_REGS);
  localparam int COMMIT_WIDTH = 2;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              regwrite;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] old_dest;
    logic [PREG_W-1:0] new_dest;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Combinational retirement decision for the two oldest ROB entries.
module rob_commit_select
  import rob_pkg::*;
(
  input  rob_entry_t        head0_i,
  input  rob_entry_t        head1_i,
  output logic              commit0_o,
  output logic              commit1_o,
  output logic              free0_en_o,
  output logic [PREG_W-1:0] free0_o,
  output logic              free1_en_o,
  output logic [PREG_W-1:0] free1_o
);

  // The younger entry may only retire alongside the older one to keep program order.
  assign commit0_o  = head0_i.valid & head0_i.done;
  assign commit1_o  = commit0_o & head1_i.valid & head1_i.done;
  assign free0_en_o = commit0_o & head0_i.regwrite;
  assign free1_en_o = commit1_o & head1_i.regwrite;
  assign free0_o    = head0_i.old_dest;
  assign free1_o    = head1_i.old_dest;

  logic unused_fields;
  assign unused_fields = ^{head0_i.rd, head0_i.new_dest, head1_i.rd, head1_i.new_dest};

endmodule

// File: rtl/reorder_buffer.sv
// Dual-issue, dual-retire in-order reorder buffer feeding the renamer free list.
// Optional performance counters are built when ROB_PERF_CNT_EN is defined.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int NUM_ENTRIES = ROB_NUM_ENTRIES,
  parameter int NUM_A_REGS  = ROB_NUM_A_REGS,
  parameter int NUM_P_REGS  = ROB_NUM_P_REGS
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           alloc0_valid_i,
  input  logic                           alloc1_valid_i,
  input  logic                           alloc0_regwrite_i,
  input  logic                           alloc1_regwrite_i,
  input  logic [4:0]                     alloc0_rd_i,
  input  logic [4:0]                     alloc1_rd_i,
  input  logic [$clog2(NUM_P_REGS)-1:0]  alloc0_old_dest_i,
  input  logic [$clog2(NUM_P_REGS)-1:0]  alloc1_old_dest_i,
  input  logic [$clog2(NUM_P_REGS)-1:0]  alloc0_new_dest_i,
  input  logic [$clog2(NUM_P_REGS)-1:0]  alloc1_new_dest_i,
  output logic                           alloc_ready_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] alloc0_idx_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] alloc1_idx_o,
  input  logic                           cmpl0_valid_i,
  input  logic                           cmpl1_valid_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cmpl0_idx_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cmpl1_idx_i,
  output logic                           free_reg0_en_o,
  output logic                           free_reg1_en_o,
  output logic [$clog2(NUM_P_REGS)-1:0]  free_reg0_o,
  output logic [$clog2(NUM_P_REGS)-1:0]  free_reg1_o,
  output logic [1:0]                     commit_count_o,
  output logic                           empty_o,
  output logic                           full_o
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_commits_o,
  output logic [31:0]                    perf_alloc_stall_o
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int AW    = $clog2(NUM_A_REGS);
  localparam logic [IDX_W:0] READY_LIMIT = (IDX_W+1)'(NUM_ENTRIES - 2);
  localparam logic [IDX_W:0] FULL_COUNT  = (IDX_W+1)'(NUM_ENTRIES);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [IDX_W:0]   count_q, count_d;
  rob_entry_t       entries [NUM_ENTRIES];

  logic              alloc_ready, alloc0_en, alloc1_en;
  logic [IDX_W-1:0]  idx0, idx1;
  logic              c0, c1, fr0_en, fr1_en;
  logic [PREG_W-1:0] fr0, fr1;
  logic [1:0]        n_alloc, n_commit;

  // Readiness looks only at the registered count, so a same-cycle retire never helps.
  assign alloc_ready = (count_q <= READY_LIMIT);
  assign alloc0_en   = alloc_ready & alloc0_valid_i;
  assign alloc1_en   = alloc_ready & alloc1_valid_i;
  assign idx0        = tail_q;
  assign idx1        = tail_q + IDX_W'(alloc0_valid_i);
  assign head1       = head_q + IDX_W'(1);

  assign n_alloc  = {1'b0, alloc0_en} + {1'b0, alloc1_en};
  assign n_commit = {1'b0, c0} + {1'b0, c1};
  assign head_d   = head_q + IDX_W'(n_commit);
  assign tail_d   = tail_q + IDX_W'(n_alloc);
  assign count_d  = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_commit);

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      rob_entry_t entry_q;
      logic       cmpl_hit, commit_hit, alloc0_hit, alloc1_hit;

      assign cmpl_hit   = (cmpl0_valid_i && cmpl0_idx_i == IDX_W'(gi)) ||
                          (cmpl1_valid_i && cmpl1_idx_i == IDX_W'(gi));
      assign commit_hit = (c0 && head_q == IDX_W'(gi)) || (c1 && head1 == IDX_W'(gi));
      assign alloc0_hit = alloc0_en && idx0 == IDX_W'(gi);
      assign alloc1_hit = alloc1_en && idx1 == IDX_W'(gi);

      // Allocation only targets free slots and retirement only valid ones, so the
      // branches never compete for the same entry in a legal cycle.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          entry_q.valid <= 1'b0;
          entry_q.done  <= 1'b0;
        end else if (alloc0_hit) begin
          entry_q <= '{valid: 1'b1, done: 1'b0, regwrite: alloc0_regwrite_i,
                       rd: alloc0_rd_i[AW-1:0], old_dest: alloc0_old_dest_i,
                       new_dest: alloc0_new_dest_i};
        end else if (alloc1_hit) begin
          entry_q <= '{valid: 1'b1, done: 1'b0, regwrite: alloc1_regwrite_i,
                       rd: alloc1_rd_i[AW-1:0], old_dest: alloc1_old_dest_i,
                       new_dest: alloc1_new_dest_i};
        end else if (commit_hit) begin
          entry_q.valid <= 1'b0;
          entry_q.done  <= 1'b0;
        end else if (cmpl_hit && entry_q.valid) begin
          entry_q.done <= 1'b1;
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  rob_commit_select u_commit_select (
    .head0_i    (entries[head_q]),
    .head1_i    (entries[head1]),
    .commit0_o  (c0),
    .commit1_o  (c1),
    .free0_en_o (fr0_en),
    .free0_o    (fr0),
    .free1_en_o (fr1_en),
    .free1_o    (fr1)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      free_reg0_en_o <= 1'b0;
      free_reg1_en_o <= 1'b0;
      free_reg0_o    <= '0;
      free_reg1_o    <= '0;
      commit_count_o <= 2'd0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      free_reg0_en_o <= fr0_en;
      free_reg1_en_o <= fr1_en;
      if (fr0_en) free_reg0_o <= fr0;
      if (fr1_en) free_reg1_o <= fr1;
      commit_count_o <= n_commit;
    end
  end

  assign alloc_ready_o = alloc_ready;
  assign alloc0_idx_o  = idx0;
  assign alloc1_idx_o  = idx1;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == FULL_COUNT);

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits_q, perf_alloc_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_commits_q     <= '0;
      perf_alloc_stall_q <= '0;
    end else begin
      perf_commits_q <= perf_commits_q + 32'(n_commit);
      if ((alloc0_valid_i | alloc1_valid_i) & ~alloc_ready)
        perf_alloc_stall_q <= perf_alloc_stall_q + 32'd1;
    end
  end

  assign perf_commits_o     = perf_commits_q;
  assign perf_alloc_stall_o = perf_alloc_stall_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts
// retirements, and a negedge monitor compares them against the free-list outputs.
module tb_reorder_buffer;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       a0v, a1v, a0rw, a1rw;
  logic [4:0] a0rd, a1rd;
  logic [5:0] a0old, a1old, a0new, a1new;
  logic       ready;
  logic [3:0] idx0, idx1;
  logic       c0v, c1v;
  logic [3:0] c0i, c1i;
  logic       f0en, f1en;
  logic [5:0] f0, f1;
  logic [1:0] ccount;
  logic       empty, full;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk_i(clk), .rst_i(rst),
    .alloc0_valid_i(a0v), .alloc1_valid_i(a1v),
    .alloc0_regwrite_i(a0rw), .alloc1_regwrite_i(a1rw),
    .alloc0_rd_i(a0rd), .alloc1_rd_i(a1rd),
    .alloc0_old_dest_i(a0old), .alloc1_old_dest_i(a1old),
    .alloc0_new_dest_i(a0new), .alloc1_new_dest_i(a1new),
    .alloc_ready_o(ready), .alloc0_idx_o(idx0), .alloc1_idx_o(idx1),
    .cmpl0_valid_i(c0v), .cmpl1_valid_i(c1v), .cmpl0_idx_i(c0i), .cmpl1_idx_i(c1i),
    .free_reg0_en_o(f0en), .free_reg1_en_o(f1en), .free_reg0_o(f0), .free_reg1_o(f1),
    .commit_count_o(ccount), .empty_o(empty), .full_o(full)
  );

  typedef struct {int tag; bit done; bit rw; int old_d;} ment_t;
  typedef struct {int n; bit en0; int f0; bit en1; int f1;} exp_t;
  typedef struct {
    bit a0v, a1v, a0rw, a1rw;
    int a0old, a0new, a1old, a1new;
    bit c0v, c1v;
    int c0i, c1i;
  } stim_t;

  ment_t mq[$];
  exp_t  eq[$];
  int    m_tail = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  function automatic void check(string name, int act, int expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // One clock of stimulus; the model is advanced with the rules of a program-order queue.
  task automatic step(input stim_t s);
    int    cnt;
    bit    rdy, m0, m1;
    exp_t  e;
    a0v = s.a0v; a1v = s.a1v; a0rw = s.a0rw; a1rw = s.a1rw;
    a0old = 6'(s.a0old); a0new = 6'(s.a0new); a1old = 6'(s.a1old); a1new = 6'(s.a1new);
    a0rd = 5'($urandom_range(0, 31)); a1rd = 5'($urandom_range(0, 31));
    c0v = s.c0v; c1v = s.c1v; c0i = 4'(s.c0i); c1i = 4'(s.c1i);
    #1;
    cnt = mq.size();
    rdy = (cnt <= N - 2);
    check("alloc_ready", int'(ready), int'(rdy));
    check("empty", int'(empty), int'(cnt == 0));
    check("full", int'(full), int'(cnt == N));
    check("alloc0_idx", int'(idx0), m_tail);
    check("alloc1_idx", int'(idx1), (m_tail + int'(s.a0v)) % N);
    @(posedge clk);
    m0 = (cnt > 0) && mq[0].done;
    m1 = m0 && (cnt > 1) && mq[1].done;
    if (m0) begin
      e.n   = m1 ? 2 : 1;
      e.en0 = mq[0].rw;
      e.f0  = mq[0].old_d;
      e.en1 = m1 && mq[1].rw;
      e.f1  = m1 ? mq[1].old_d : 0;
      eq.push_back(e);
    end
    foreach (mq[i])
      if ((s.c0v && mq[i].tag == s.c0i) || (s.c1v && mq[i].tag == s.c1i)) mq[i].done = 1'b1;
    if (m0) void'(mq.pop_front());
    if (m1) void'(mq.pop_front());
    if (rdy) begin
      if (s.a0v) begin mq.push_back('{m_tail, 1'b0, s.a0rw, s.a0old}); m_tail = (m_tail + 1) % N; end
      if (s.a1v) begin mq.push_back('{m_tail, 1'b0, s.a1rw, s.a1old}); m_tail = (m_tail + 1) % N; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    mq.delete();
    m_tail = 0;
    #1 rst = 1'b0;
  endtask

  function automatic stim_t alloc2(bit rw0, bit rw1);
    stim_t s;
    s = idle();
    s.a0v = 1; s.a0rw = rw0; s.a0old = $urandom_range(0, 63); s.a0new = $urandom_range(0, 63);
    s.a1v = 1; s.a1rw = rw1; s.a1old = $urandom_range(0, 63); s.a1new = $urandom_range(0, 63);
    return s;
  endfunction

  function automatic stim_t with_cmpl(stim_t base, bit v0, int t0, bit v1, int t1);
    stim_t s;
    s = base;
    s.c0v = v0; s.c0i = t0; s.c1v = v1; s.c1i = t1;
    return s;
  endfunction

  // Monitor: every retirement the DUT reports must match the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ccount != 2'd0) begin
        if (eq.size() == 0) begin
          check("unexpected_commit", int'(ccount), 0);
        end else begin
          e = eq.pop_front();
          $display("retire n=%0d en0=%0d f0=%0d en1=%0d f1=%0d", ccount, f0en, f0, f1en, f1);
          check("commit_count", int'(ccount), e.n);
          check("free0_en", int'(f0en), int'(e.en0));
          if (e.en0) check("free0_tag", int'(f0), e.f0);
          check("free1_en", int'(f1en), int'(e.en1));
          if (e.en1) check("free1_tag", int'(f1), e.f1);
        end
      end else begin
        if (eq.size() != 0) begin
          e = eq.pop_front();
          check("missing_commit", 0, e.n);
        end
        check("idle_free0_en", int'(f0en), 0);
        check("idle_free1_en", int'(f1en), 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    int    t0, t1;
    rst = 1'b1;
    a0v = 0; a1v = 0; a0rw = 0; a1rw = 0; a0rd = 0; a1rd = 0;
    a0old = 0; a1old = 0; a0new = 0; a1new = 0;
    c0v = 0; c1v = 0; c0i = 0; c1i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then an out-of-order completion pair with known tags.
    step(idle());
    s = idle();
    s.a0v = 1; s.a0rw = 1; s.a0old = 5; s.a0new = 33;
    s.a1v = 1; s.a1rw = 1; s.a1old = 7; s.a1new = 34;
    step(s);
    step(with_cmpl(idle(), 1, 1, 0, 0));
    step(idle());
    step(idle());
    step(with_cmpl(idle(), 1, 0, 0, 0));
    step(idle());
    step(idle());

    // Fill to capacity, push against the full buffer, then retire out of order.
    do_reset();
    for (int k = 0; k < 8; k++) step(alloc2(k != 0, 1'b1));
    step(alloc2(1'b1, 1'b1));
    step(with_cmpl(idle(), 1, 1, 0, 0));
    step(idle());
    step(with_cmpl(idle(), 1, 0, 0, 0));
    step(idle());
    for (int k = 1; k < 8; k++) step(with_cmpl(idle(), 1, 2 * k, 1, 2 * k + 1));
    repeat (3) step(idle());

    // Walk head to 14, then allocate and retire across the wrap boundary.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      s = (k < 7) ? alloc2(1'b1, 1'b0) : idle();
      if (k > 0) s = with_cmpl(s, 1, 2 * (k - 1), 1, 2 * (k - 1) + 1);
      step(s);
    end
    repeat (3) step(idle());
    step(alloc2(1'b1, 1'b1));
    step(with_cmpl(alloc2(1'b1, 1'b1), 1, 14, 1, 15));
    step(alloc2(1'b1, 1'b1));
    step(with_cmpl(idle(), 1, 0, 1, 1));
    step(with_cmpl(idle(), 1, 2, 1, 3));
    repeat (3) step(idle());

    // Reset with six live entries: stale completion ignored, allocation restarts at 0.
    do_reset();
    for (int k = 0; k < 3; k++) step(alloc2(1'b1, 1'b1));
    do_reset();
    s = idle();
    s.a0v = 1; s.a0rw = 1; s.a0old = 9; s.a0new = 40;
    step(with_cmpl(s, 1, 3, 0, 0));
    step(with_cmpl(idle(), 1, 0, 0, 0));
    repeat (2) step(idle());

    // Randomised traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      s = alloc2($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      s.a0v = ($urandom_range(0, 99) < 55);
      s.a1v = ($urandom_range(0, 99) < 45);
      t0 = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : $urandom_range(0, N - 1);
      t1 = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) == 0) t1 = $urandom_range(0, N - 1);
      s = with_cmpl(s, $urandom_range(0, 99) < 60, t0, $urandom_range(0, 99) < 50, t1);
      step(s);
      if ($urandom_range(0, 249) == 0) do_reset();
    end
    for (int k = 0; k < 100 && mq.size() > 0; k++) begin
      t0 = mq[0].tag;
      t1 = (mq.size() > 1) ? mq[1].tag : mq[0].tag;
      step(with_cmpl(idle(), 1, t0, 1, t1));
    end
    check("model_drained", mq.size(), 0);
    repeat (3) step(idle());
    check("scoreboard_drained", eq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
